result_reader: RTL and testbench

RESULT_READER -- requirements
Module: result_reader

---
 rtl/result_reader.sv | 84 ++++++++
 tb/tb_result_reader.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/result_reader.sv
// result_reader: streams a LEN-word burst out of a read buffer, one word per READ/LATCH/SEND pass.
//   clk, rst        : clock, asynchronous active-high reset
//   start           : pulse, buffer holds LEN valid words (honoured only in IDLE)
//   mem_rd_en/addr  : buffer read strobe and address
//   mem_rdata       : buffer data, valid one cycle after mem_rd_en
//   out_data/valid  : registered word offered downstream, held until out_ready
//   out_ready       : downstream accept
//   busy            : high outside IDLE
//   done            : one-cycle pulse after the last word is accepted
module result_reader #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4,
    parameter int LEN    = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy,
    output logic              done
);
    typedef enum logic [2:0] {IDLE, READ, LATCH, SEND, FINISH} state_t;
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(LEN - 1);
    state_t            state;
    logic [ADDR_W-1:0] cnt;
    // Outputs are registered: each transition loads the output values of the state being entered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            out_data  <= '0;
            mem_rd_en <= 1'b0;
            mem_addr  <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            mem_rd_en <= 1'b0;
            done      <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    state     <= READ;
                    cnt       <= '0;
                    mem_addr  <= '0;
                    mem_rd_en <= 1'b1;
                    busy      <= 1'b1;
                end
                READ: state <= LATCH;
                LATCH: begin
                    out_data  <= mem_rdata;
                    out_valid <= 1'b1;
                    state     <= SEND;
                end
                SEND: if (out_ready) begin
                    out_valid <= 1'b0;
                    if (cnt == LAST) begin
                        state <= FINISH;
                        done  <= 1'b1;
                    end else begin
                        // counter and address advance together so the address is ready in READ
                        cnt       <= cnt + 1'b1;
                        mem_addr  <= cnt + 1'b1;
                        mem_rd_en <= 1'b1;
                        state     <= READ;
                    end
                end
                FINISH: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state     <= IDLE;
                    busy      <= 1'b0;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_result_reader.sv
// tb_result_reader: directed self-checking bench for result_reader (LEN=4, LEN=16, LEN=1 instances).
module tb_result_reader;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [7:0] mem [16];
    int checks = 0;
    int failures = 0;

    function automatic logic [7:0] exp_word(input int i);
        return 8'(8'h11 * (i + 1));
    endfunction

    logic       start4 = 0, ready4 = 1, rd4, valid4, busy4, done4;
    logic [3:0] addr4;
    logic [7:0] rdata4 = 0, data4;
    logic       start16 = 0, rd16, valid16, busy16, done16;
    logic [3:0] addr16;
    logic [7:0] rdata16 = 0, data16;
    logic       start1 = 0, rd1, valid1, busy1, done1;
    logic [3:0] addr1;
    logic [7:0] rdata1 = 0, data1;

    result_reader #(.DATA_W(8), .ADDR_W(4), .LEN(4)) u4 (
        .clk(clk), .rst(rst), .start(start4), .mem_rd_en(rd4), .mem_addr(addr4),
        .mem_rdata(rdata4), .out_data(data4), .out_valid(valid4), .out_ready(ready4),
        .busy(busy4), .done(done4));
    result_reader #(.DATA_W(8), .ADDR_W(4), .LEN(16)) u16 (
        .clk(clk), .rst(rst), .start(start16), .mem_rd_en(rd16), .mem_addr(addr16),
        .mem_rdata(rdata16), .out_data(data16), .out_valid(valid16), .out_ready(1'b1),
        .busy(busy16), .done(done16));
    result_reader #(.DATA_W(8), .ADDR_W(4), .LEN(1)) u1 (
        .clk(clk), .rst(rst), .start(start1), .mem_rd_en(rd1), .mem_addr(addr1),
        .mem_rdata(rdata1), .out_data(data1), .out_valid(valid1), .out_ready(1'b1),
        .busy(busy1), .done(done1));

    always @(posedge clk) begin
        if (rd4) rdata4 <= mem[addr4];
        if (rd16) rdata16 <= mem[addr16];
        if (rd1) rdata1 <= mem[addr1];
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        #1;
        checks++; if ({rd4, addr4, data4, valid4, busy4, done4} !== 16'h0) begin failures++; $display("FAIL reset_u4 got=%h exp=0", {rd4, addr4, data4, valid4, busy4, done4}); end
        checks++; if ({rd16, addr16, data16, valid16, busy16, done16} !== 16'h0) begin failures++; $display("FAIL reset_u16 got=%h exp=0", {rd16, addr16, data16, valid16, busy16, done16}); end
        checks++; if ({rd1, addr1, data1, valid1, busy1, done1} !== 16'h0) begin failures++; $display("FAIL reset_u1 got=%h exp=0", {rd1, addr1, data1, valid1, busy1, done1}); end
        tick; tick;
        rst = 0;
        tick; tick;
        checks++; if (busy4 !== 1'b0) begin failures++; $display("FAIL idle_after_reset busy=%b exp=0", busy4); end
    endtask

    task automatic test_nominal;
        logic ev, er;
        ready4 = 1;
        start4 = 1;
        for (int c = 0; c < 16; c++) begin
            ev = (c >= 3 && c <= 12 && c % 3 == 0);
            er = (c >= 1 && c <= 10 && c % 3 == 1);
            checks++; if (valid4 !== ev) begin failures++; $display("FAIL nom_valid c=%0d got=%b exp=%b", c, valid4, ev); end
            checks++; if (rd4 !== er) begin failures++; $display("FAIL nom_rd c=%0d got=%b exp=%b", c, rd4, er); end
            checks++; if (busy4 !== (c >= 1 && c <= 13)) begin failures++; $display("FAIL nom_busy c=%0d got=%b", c, busy4); end
            checks++; if (done4 !== (c == 13)) begin failures++; $display("FAIL nom_done c=%0d got=%b", c, done4); end
            if (er) begin
                checks++; if (addr4 !== 4'((c - 1) / 3)) begin failures++; $display("FAIL nom_addr c=%0d got=%0d exp=%0d", c, addr4, (c - 1) / 3); end
            end
            if (ev) begin
                checks++; if (data4 !== exp_word((c - 3) / 3)) begin failures++; $display("FAIL nom_data c=%0d got=%h exp=%h", c, data4, exp_word((c - 3) / 3)); end
            end
            tick;
            start4 = 0;
        end
    endtask

    task automatic test_backpressure;
        logic [7:0] got [8];
        int n = 0, nrd = 0, nd = 0;
        start4 = 1;
        for (int c = 0; c < 23; c++) begin
            ready4 = !(c >= 9 && c <= 13);
            if (c >= 9 && c <= 14) begin
                checks++; if ({valid4, data4, rd4} !== {1'b1, 8'h33, 1'b0}) begin failures++; $display("FAIL bp_hold c=%0d got v=%b d=%h rd=%b exp v=1 d=33 rd=0", c, valid4, data4, rd4); end
            end
            if (valid4 && ready4 && n < 8) begin got[n] = data4; n++; end
            if (rd4) nrd++;
            if (done4) begin
                nd++;
                checks++; if (c != 18) begin failures++; $display("FAIL bp_done_cycle got=%0d exp=18", c); end
            end
            tick;
            start4 = 0;
        end
        ready4 = 1;
        checks++; if (n != 4) begin failures++; $display("FAIL bp_words got=%0d exp=4", n); end
        for (int i = 0; i < 4 && i < n; i++) begin
            checks++; if (got[i] !== exp_word(i)) begin failures++; $display("FAIL bp_order i=%0d got=%h exp=%h", i, got[i], exp_word(i)); end
        end
        checks++; if (nrd != 4) begin failures++; $display("FAIL bp_reads got=%0d exp=4", nrd); end
        checks++; if (nd != 1) begin failures++; $display("FAIL bp_dones got=%0d exp=1", nd); end
    endtask

    task automatic test_ignored_start;
        int hs = 0, nrd = 0, nd = 0;
        ready4 = 1;
        for (int c = 0; c < 21; c++) begin
            start4 = (c == 0 || c == 3 || c == 13);
            if (rd4) begin
                checks++; if (addr4 !== 4'(nrd)) begin failures++; $display("FAIL ign_addr got=%0d exp=%0d", addr4, nrd); end
                nrd++;
            end
            if (valid4 && ready4) hs++;
            if (done4) nd++;
            if (c == 14) begin
                checks++; if ({busy4, rd4} !== 2'b00) begin failures++; $display("FAIL ign_restart busy=%b rd=%b exp 0 0", busy4, rd4); end
            end
            tick;
        end
        start4 = 0;
        checks++; if (hs != 4) begin failures++; $display("FAIL ign_words got=%0d exp=4", hs); end
        checks++; if (nrd != 4) begin failures++; $display("FAIL ign_reads got=%0d exp=4", nrd); end
        checks++; if (nd != 1) begin failures++; $display("FAIL ign_dones got=%0d exp=1", nd); end
    endtask

    task automatic test_reset_mid;
        ready4 = 1;
        start4 = 1;
        for (int c = 0; c < 6; c++) begin
            tick;
            start4 = 0;
        end
        checks++; if ({valid4, data4} !== {1'b1, 8'h22}) begin failures++; $display("FAIL rm_pre got v=%b d=%h exp v=1 d=22", valid4, data4); end
        #2 rst = 1;
        #1;
        checks++; if ({rd4, addr4, data4, valid4, busy4, done4} !== 16'h0) begin failures++; $display("FAIL rm_outputs got=%h exp=0", {rd4, addr4, data4, valid4, busy4, done4}); end
        tick; tick;
        rst = 0;
        for (int c = 0; c < 6; c++) begin
            checks++; if ({done4, busy4} !== 2'b00) begin failures++; $display("FAIL rm_quiet c=%0d done=%b busy=%b", c, done4, busy4); end
            tick;
        end
        start4 = 1;
        tick;
        start4 = 0;
        checks++; if ({rd4, addr4} !== 5'b1_0000) begin failures++; $display("FAIL rm_restart rd=%b addr=%0d exp rd=1 addr=0", rd4, addr4); end
        tick; tick;
        checks++; if ({valid4, data4} !== {1'b1, 8'h11}) begin failures++; $display("FAIL rm_first got v=%b d=%h exp v=1 d=11", valid4, data4); end
        for (int c = 0; c < 12; c++) tick;
        checks++; if (busy4 !== 1'b0) begin failures++; $display("FAIL rm_drain busy=%b exp=0", busy4); end
    endtask

    task automatic test_full_depth;
        int seen [16];
        int nd = 0, hs = 0, done_c = -1;
        logic [3:0] last_addr = 0;
        for (int i = 0; i < 16; i++) seen[i] = 0;
        start16 = 1;
        for (int c = 0; c < 53; c++) begin
            if (rd16) begin seen[addr16]++; last_addr = addr16; end
            if (valid16) begin
                checks++; if (data16 !== exp_word(hs)) begin failures++; $display("FAIL fd_data i=%0d got=%h exp=%h", hs, data16, exp_word(hs)); end
                hs++;
            end
            if (done16) begin nd++; done_c = c; end
            tick;
            start16 = 0;
        end
        for (int i = 0; i < 16; i++) begin
            checks++; if (seen[i] != 1) begin failures++; $display("FAIL fd_addr a=%0d reads=%0d exp=1", i, seen[i]); end
        end
        checks++; if (last_addr !== 4'hF) begin failures++; $display("FAIL fd_last got=%0d exp=15", last_addr); end
        checks++; if (hs != 16) begin failures++; $display("FAIL fd_words got=%0d exp=16", hs); end
        checks++; if (nd != 1) begin failures++; $display("FAIL fd_dones got=%0d exp=1", nd); end
        checks++; if (done_c != 49) begin failures++; $display("FAIL fd_done_cycle got=%0d exp=49", done_c); end
    endtask

    task automatic test_len1;
        start1 = 1;
        for (int c = 0; c < 8; c++) begin
            checks++; if ({rd1, valid1, done1, busy1} !== {c == 1, c == 3, c == 4, c >= 1 && c <= 4}) begin failures++; $display("FAIL len1 c=%0d got rd/v/d/b=%b%b%b%b", c, rd1, valid1, done1, busy1); end
            if (c == 3) begin
                checks++; if ({addr1, data1} !== {4'h0, 8'h11}) begin failures++; $display("FAIL len1_data got a=%0d d=%h exp a=0 d=11", addr1, data1); end
            end
            tick;
            start1 = 0;
        end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = exp_word(i);
        test_reset;
        test_nominal;
        test_backpressure;
        test_ignored_start;
        test_reset_mid;
        test_full_depth;
        test_len1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
